// File: rtl/gfx_pkts_arbiter_pkg.sv
// Shared definitions for the gfx packet arbiter and its pick logic.
//   ARB_RR / ARB_PRIO : arbitration mode select values
//   arb_state_e       : arbiter FSM state encoding (IDLE, LOCKED)
package gfx_pkts_arbiter_pkg;

  localparam logic ARB_RR   = 1'b0;
  localparam logic ARB_PRIO = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/gfx_pkts_arbiter_rr.sv
// gfx_rr_pick: combinational winner selection over a request vector.
//   req     : per-channel request
//   rr_ptr  : round-robin start index (ignored in priority mode)
//   mode    : ARB_RR scans from rr_ptr upward with wrap, ARB_PRIO picks lowest index
//   winner  : selected index (0 when nothing requests)
//   any_req : at least one request present
module gfx_rr_pick
  import gfx_pkts_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         req,
  input  logic [IDX_WIDTH-1:0] rr_ptr,
  input  logic                 mode,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 any_req
);

  int   idx;
  logic found;

  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx     = 0;
    any_req = |req;
    for (int k = 0; k < N; k++) begin
      if (mode == ARB_PRIO) begin
        idx = k;
      end else begin
        idx = (int'(rr_ptr) + k) % N;
      end
      if (!found && req[idx]) begin
        winner = IDX_WIDTH'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gfx_pkts_arbiter.sv
// gfx_pkts_arbiter: N-to-1 packet-granular stream arbiter with one registered
// output stage. A winner is locked from its first beat until its tlast beat is
// accepted, so beats of different packets never interleave.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_tdata/tlast/tvalid, in_tready : per-channel input streams
//   out_tdata/tlast/tid/tvalid, out_tready : registered output stream + source id
//   busy                : a packet is currently locked
//   pkts_done           : packets fully forwarded into the output register
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no packet owned; all in_tready low; pick winner if any valid
// ST_LOCKED | grant owns the port until its tlast beat is accepted
module gfx_pkts_arbiter
  import gfx_pkts_arbiter_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int ID_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  in_tdata,
  input  logic [CHANNELS-1:0]                  in_tlast,
  input  logic [CHANNELS-1:0]                  in_tvalid,
  output logic [CHANNELS-1:0]                  in_tready,
  output logic [DATA_WIDTH-1:0]                out_tdata,
  output logic                                 out_tlast,
  output logic [ID_WIDTH-1:0]                  out_tid,
  output logic                                 out_tvalid,
  input  logic                                 out_tready,
  output logic                                 busy,
  output logic [CNT_WIDTH-1:0]                 pkts_done
);

  localparam logic                MODE_SEL = (ARB_MODE == 1) ? ARB_PRIO : ARB_RR;
  localparam logic [ID_WIDTH-1:0] LAST_CH  = ID_WIDTH'(CHANNELS - 1);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] rr_ptr_nxt;
  logic [ID_WIDTH-1:0] winner;
  logic                any_req;
  logic                load_en;
  logic                beat_acc;
  logic                beat_last;

  gfx_rr_pick #(
    .N         (CHANNELS),
    .IDX_WIDTH (ID_WIDTH)
  ) u_pick (
    .req     (in_tvalid),
    .rr_ptr  (rr_ptr_q),
    .mode    (MODE_SEL),
    .winner  (winner),
    .any_req (any_req)
  );

  // The output register can take a new beat when empty or draining this cycle.
  assign load_en    = !out_tvalid || out_tready;
  assign beat_acc   = (state_q == ST_LOCKED) && in_tvalid[grant_q] && load_en;
  assign beat_last  = in_tlast[grant_q];
  // Explicit wrap keeps the pointer legal for non-power-of-two channel counts.
  assign rr_ptr_nxt = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (beat_acc && beat_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: ready depends only on state, grant and output-register status,
  // never on in_tvalid.
  always_comb begin
    in_tready = '0;
    busy      = 1'b0;
    if (state_q == ST_LOCKED) begin
      busy               = 1'b1;
      in_tready[grant_q] = load_en;
    end
  end

  // Grant and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && any_req) begin
        grant_q <= winner;
      end
      if (beat_acc && beat_last) begin
        rr_ptr_q <= rr_ptr_nxt;
      end
    end
  end

  // Output register and packet counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
      out_tvalid <= 1'b0;
      pkts_done  <= '0;
    end else begin
      if (beat_acc) begin
        out_tdata  <= in_tdata[grant_q];
        out_tlast  <= beat_last;
        out_tid    <= grant_q;
        out_tvalid <= 1'b1;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end
      if (beat_acc && beat_last) begin
        pkts_done <= pkts_done + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gfx_pkts_arbiter.sv
// Bench for gfx_pkts_arbiter: instance 0 is round-robin, instance 1 is fixed
// priority. A per-cycle behavioural model is compared against both instances,
// and directed scenarios add hand-computed literal expectations.
module tb_gfx_pkts_arbiter;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int CW = 16;

  logic clk;
  logic rst_n;

  logic [CH-1:0][DW-1:0] tdata  [2];
  logic [CH-1:0]         tlast  [2];
  logic [CH-1:0]         tvalid [2];
  logic [CH-1:0]         tready [2];
  logic [DW-1:0]         odata  [2];
  logic                  olast  [2];
  logic [IW-1:0]         otid   [2];
  logic                  ovalid [2];
  logic                  oready [2];
  logic                  busy   [2];
  logic [CW-1:0]         done   [2];

  gfx_pkts_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .ARB_MODE(0), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(tdata[0]), .in_tlast(tlast[0]), .in_tvalid(tvalid[0]), .in_tready(tready[0]),
    .out_tdata(odata[0]), .out_tlast(olast[0]), .out_tid(otid[0]), .out_tvalid(ovalid[0]),
    .out_tready(oready[0]), .busy(busy[0]), .pkts_done(done[0])
  );

  gfx_pkts_arbiter #(.CHANNELS(CH), .DATA_WIDTH(DW), .ARB_MODE(1), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .in_tdata(tdata[1]), .in_tlast(tlast[1]), .in_tvalid(tvalid[1]), .in_tready(tready[1]),
    .out_tdata(odata[1]), .out_tlast(olast[1]), .out_tid(otid[1]), .out_tvalid(ovalid[1]),
    .out_tready(oready[1]), .busy(busy[1]), .pkts_done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Source side: per-channel queue of beats {last, data}, plus a valid enable.
  logic [DW:0]   srcq [2][CH][$];
  logic [CH-1:0] en   [2];
  int            rdyq [2][$];

  // Model state
  bit            m_lock  [2];
  int            m_grant [2];
  int            m_ptr   [2];
  bit            m_ov    [2];
  logic [DW-1:0] m_od    [2];
  bit            m_ol    [2];
  int            m_oid   [2];
  int            m_cnt   [2];

  int            gtrace  [2][$];
  logic [DW-1:0] lg_data [2][$];
  int            lg_tid  [2][$];
  bit            lg_last [2][$];
  int            lg_cyc  [2][$];

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lock[d]  = 1'b0;
      m_grant[d] = 0;
      m_ptr[d]   = 0;
      m_ov[d]    = 1'b0;
      m_od[d]    = '0;
      m_ol[d]    = 1'b0;
      m_oid[d]   = 0;
      m_cnt[d]   = 0;
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      gtrace[d].delete();
      lg_data[d].delete();
      lg_tid[d].delete();
      lg_last[d].delete();
      lg_cyc[d].delete();
    end
  endtask

  task automatic push_pkt(int d, int c, int base, int n);
    logic [DW:0] v;
    for (int b = 0; b < n; b++) begin
      v = {(b == n - 1), DW'(base + b)};
      srcq[d][c].push_back(v);
    end
  endtask

  task automatic drive_inputs();
    logic [DW:0] b;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (en[d][c] && srcq[d][c].size() > 0) begin
          b = srcq[d][c][0];
          tvalid[d][c] = 1'b1;
          tdata[d][c]  = b[DW-1:0];
          tlast[d][c]  = b[DW];
        end else begin
          tvalid[d][c] = 1'b0;
          tdata[d][c]  = '0;
          tlast[d][c]  = 1'b0;
        end
      end
      if (rdyq[d].size() > 0) oready[d] = (rdyq[d].pop_front() != 0);
      else                    oready[d] = 1'b1;
    end
  endtask

  task automatic compare(int d);
    logic [CH-1:0] er;
    er = '0;
    if (m_lock[d] && (!m_ov[d] || oready[d])) er[m_grant[d]] = 1'b1;
    chk($sformatf("d%0d in_tready", d), 64'(tready[d]), 64'(er));
    chk($sformatf("d%0d out_tvalid", d), 64'(ovalid[d]), 64'(m_ov[d]));
    if (m_ov[d]) begin
      chk($sformatf("d%0d out_tdata", d), 64'(odata[d]), 64'(m_od[d]));
      chk($sformatf("d%0d out_tlast", d), 64'(olast[d]), 64'(m_ol[d]));
      chk($sformatf("d%0d out_tid", d), 64'(otid[d]), 64'(m_oid[d]));
    end
    chk($sformatf("d%0d busy", d), 64'(busy[d]), 64'(m_lock[d]));
    chk($sformatf("d%0d pkts_done", d), 64'(done[d]), 64'(CW'(m_cnt[d])));
  endtask

  task automatic tick();
    logic [CH-1:0] acc [2];
    bit            n_lock [2];
    int            n_grant [2];
    int            n_ptr [2];
    bit            n_ov [2];
    logic [DW-1:0] n_od [2];
    bit            n_ol [2];
    int            n_oid [2];
    int            n_cnt [2];
    bit            found;
    int            idx;
    drive_inputs();
    #1;
    for (int d = 0; d < 2; d++) begin
      compare(d);
      acc[d] = tvalid[d] & tready[d];
      if (ovalid[d] && oready[d]) begin
        lg_data[d].push_back(odata[d]);
        lg_tid[d].push_back(int'(otid[d]));
        lg_last[d].push_back(olast[d]);
        lg_cyc[d].push_back(cyc);
      end
      n_lock[d] = m_lock[d]; n_grant[d] = m_grant[d]; n_ptr[d] = m_ptr[d];
      n_ov[d] = m_ov[d]; n_od[d] = m_od[d]; n_ol[d] = m_ol[d];
      n_oid[d] = m_oid[d]; n_cnt[d] = m_cnt[d];
      if (!m_lock[d]) begin
        if (m_ov[d] && oready[d]) n_ov[d] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < CH; k++) begin
          idx = (d == 1) ? k : (m_ptr[d] + k) % CH;
          if (!found && tvalid[d][idx]) begin
            found = 1'b1;
            n_grant[d] = idx;
            n_lock[d] = 1'b1;
            if (rst_n) gtrace[d].push_back(idx);
          end
        end
      end else if ((!m_ov[d] || oready[d]) && tvalid[d][m_grant[d]]) begin
        n_ov[d]  = 1'b1;
        n_od[d]  = tdata[d][m_grant[d]];
        n_ol[d]  = tlast[d][m_grant[d]];
        n_oid[d] = m_grant[d];
        if (tlast[d][m_grant[d]]) begin
          n_cnt[d]  = m_cnt[d] + 1;
          n_ptr[d]  = (m_grant[d] + 1) % CH;
          n_lock[d] = 1'b0;
        end
      end else if (oready[d]) begin
        n_ov[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (acc[d][c] && srcq[d][c].size() > 0) void'(srcq[d][c].pop_front());
      end
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_lock[d] = n_lock[d]; m_grant[d] = n_grant[d]; m_ptr[d] = n_ptr[d];
        m_ov[d] = n_ov[d]; m_od[d] = n_od[d]; m_ol[d] = n_ol[d];
        m_oid[d] = n_oid[d]; m_cnt[d] = n_cnt[d];
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic bit is_idle(int d);
    bit r;
    r = !m_lock[d] && !m_ov[d];
    for (int c = 0; c < CH; c++) begin
      if (srcq[d][c].size() > 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle(int d);
    int n;
    n = 0;
    while (!is_idle(d) && n < 400) begin
      tick();
      n++;
    end
    chk($sformatf("d%0d drained", d), 64'(is_idle(d)), 64'd1);
  endtask

  initial begin
    int c0;
    int n;
    int bad;
    rst_n = 1'b0;
    en[0] = '1;
    en[1] = '1;
    model_reset();
    drive_inputs();
    #1;
    chk("reset out_tvalid", 64'(ovalid[0]), 64'd0);
    chk("reset out_tdata", 64'(odata[0]), 64'd0);
    chk("reset out_tid", 64'(otid[0]), 64'd0);
    chk("reset busy", 64'(busy[0]), 64'd0);
    chk("reset pkts_done", 64'(done[0]), 64'd0);
    chk("reset in_tready", 64'(tready[0]), 64'd0);
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single channel, 3-beat packet on ch1
    clear_logs();
    c0 = cyc;
    push_pkt(0, 1, 'h11, 3);
    wait_idle(0);
    chk("t1 beats", 64'(lg_data[0].size()), 64'd3);
    chk("t1 beat0", 64'(lg_data[0][0]), 64'h11);
    chk("t1 beat1", 64'(lg_data[0][1]), 64'h12);
    chk("t1 beat2", 64'(lg_data[0][2]), 64'h13);
    chk("t1 tid", 64'(lg_tid[0][0]), 64'd1);
    chk("t1 last", 64'(lg_last[0][2]), 64'd1);
    chk("t1 latency", 64'(lg_cyc[0][0] - c0), 64'd2);
    chk("t1 back2back", 64'(lg_cyc[0][2] - lg_cyc[0][0]), 64'd2);
    chk("t1 pkts_done", 64'(done[0]), 64'd1);

    // rr_ptr is now 2: ch3 must beat ch0
    clear_logs();
    push_pkt(0, 0, 'h20, 1);
    push_pkt(0, 3, 'h30, 1);
    wait_idle(0);
    chk("t1b model first", 64'(gtrace[0][0]), 64'd3);
    chk("t1b dut first tid", 64'(lg_tid[0][0]), 64'd3);
    chk("t1b dut second tid", 64'(lg_tid[0][1]), 64'd0);

    // Quiet reset, then round-robin fairness with 2-beat packets
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    clear_logs();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < CH; c++) push_pkt(0, c, (c << 8) | (p << 4), 2);
    end
    wait_idle(0);
    chk("t2 beats", 64'(lg_data[0].size()), 64'd16);
    chk("t2 model g0", 64'(gtrace[0][0]), 64'd0);
    chk("t2 model g4", 64'(gtrace[0][4]), 64'd0);
    chk("t2 tid p0", 64'(lg_tid[0][0]), 64'd0);
    chk("t2 tid p1", 64'(lg_tid[0][2]), 64'd1);
    chk("t2 tid p2", 64'(lg_tid[0][4]), 64'd2);
    chk("t2 tid p3", 64'(lg_tid[0][6]), 64'd3);
    chk("t2 tid p4", 64'(lg_tid[0][8]), 64'd0);
    chk("t2 data p4b1", 64'(lg_data[0][9]), 64'h11);
    bad = 0;
    for (int i = 0; i + 1 < lg_data[0].size(); i++) begin
      if (!lg_last[0][i] && lg_tid[0][i + 1] != lg_tid[0][i]) bad++;
      if (!lg_last[0][i] && lg_cyc[0][i + 1] - lg_cyc[0][i] != 1) bad++;
      if (lg_last[0][i] && lg_cyc[0][i + 1] - lg_cyc[0][i] != 2) bad++;
    end
    chk("t2 grouping/gaps", 64'(bad), 64'd0);

    // Fixed priority: ch0 keeps requesting, ch3 starves until ch0 runs dry
    clear_logs();
    for (int p = 0; p < 3; p++) push_pkt(1, 0, 'h40 + (p << 4), 2);
    push_pkt(1, 3, 'h70, 2);
    wait_idle(1);
    chk("t3 grants", 64'(gtrace[1].size()), 64'd4);
    chk("t3 model g2", 64'(gtrace[1][2]), 64'd0);
    chk("t3 model g3", 64'(gtrace[1][3]), 64'd3);
    chk("t3 dut tid5", 64'(lg_tid[1][5]), 64'd0);
    chk("t3 dut tid6", 64'(lg_tid[1][6]), 64'd3);
    chk("t3 dut data6", 64'(lg_data[1][6]), 64'h70);

    // Backpressure during a 4-beat packet
    clear_logs();
    rdyq[0] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1};
    push_pkt(0, 0, 'hA0, 4);
    wait_idle(0);
    chk("t4 beats", 64'(lg_data[0].size()), 64'd4);
    chk("t4 beat0", 64'(lg_data[0][0]), 64'hA0);
    chk("t4 beat1", 64'(lg_data[0][1]), 64'hA1);
    chk("t4 beat2", 64'(lg_data[0][2]), 64'hA2);
    chk("t4 beat3", 64'(lg_data[0][3]), 64'hA3);

    // Source stall mid-packet on ch2 while ch0 waits (rr_ptr is 1)
    clear_logs();
    push_pkt(0, 2, 'hC0, 4);
    push_pkt(0, 0, 'hD0, 1);
    n = 0;
    while (srcq[0][2].size() > 3 && n < 50) begin
      tick();
      n++;
    end
    chk("t5 first beat taken", 64'(srcq[0][2].size()), 64'd3);
    en[0][2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5 busy held", 64'(busy[0]), 64'd1);
      chk("t5 ch0 ready", 64'(tready[0][0]), 64'd0);
    end
    en[0][2] = 1'b1;
    wait_idle(0);
    chk("t5 model g0", 64'(gtrace[0][0]), 64'd2);
    chk("t5 dut beat3", 64'(lg_data[0][3]), 64'hC3);
    chk("t5 dut tid3", 64'(lg_tid[0][3]), 64'd2);
    chk("t5 dut tid4", 64'(lg_tid[0][4]), 64'd0);

    // Reset in the middle of a ch1 packet
    clear_logs();
    push_pkt(0, 1, 'hE0, 4);
    n = 0;
    while (lg_data[0].size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t6 two beats out", 64'(lg_data[0].size()), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("t6 async out_tvalid", 64'(ovalid[0]), 64'd0);
    chk("t6 async pkts_done", 64'(done[0]), 64'd0);
    chk("t6 async busy", 64'(busy[0]), 64'd0);
    chk("t6 async in_tready", 64'(tready[0]), 64'd0);
    model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) srcq[d][c].delete();
    end
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    push_pkt(0, 0, 'hF0, 2);
    wait_idle(0);
    chk("t6 beats", 64'(lg_data[0].size()), 64'd2);
    chk("t6 tid", 64'(lg_tid[0][0]), 64'd0);
    chk("t6 beat0", 64'(lg_data[0][0]), 64'hF0);
    chk("t6 beat1", 64'(lg_data[0][1]), 64'hF1);
    chk("t6 pkts_done", 64'(done[0]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
